// File: rtl/layered_ctrl_bank_pkg.sv
// Shared definitions for the layered control bank: command opcodes, the
// parser write-strobe payload, the payload-length lookup and the helper that
// locates a layer's slice in a flattened per-layer bus.
package layered_ctrl_bank_pkg;

    localparam int unsigned REG_W   = 4;
    localparam int unsigned LAYER_W = 4;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ACC_W   = 16;
    localparam int unsigned LEN_W   = 2;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned SCALE_W = 2;
    localparam int unsigned ERR_W   = 8;

    localparam logic [REG_W-1:0] REG_MODE    = 4'd0;
    localparam logic [REG_W-1:0] REG_SCALE   = 4'd1;
    localparam logic [REG_W-1:0] REG_TRANSP  = 4'd2;
    localparam logic [REG_W-1:0] REG_OFS_X   = 4'd3;
    localparam logic [REG_W-1:0] REG_OFS_Y   = 4'd4;
    localparam logic [REG_W-1:0] REG_CLIP_L  = 4'd5;
    localparam logic [REG_W-1:0] REG_CLIP_R  = 4'd6;
    localparam logic [REG_W-1:0] REG_CLIP_T  = 4'd7;
    localparam logic [REG_W-1:0] REG_CLIP_B  = 4'd8;
    localparam logic [REG_W-1:0] REG_FILTER  = 4'd9;
    localparam logic [REG_W-1:0] REG_FREEZE  = 4'd14;
    localparam logic [REG_W-1:0] REG_COMMIT  = 4'd15;

    // Completed field write from the parser to the shadow bank.
    typedef struct packed {
        logic [REG_W-1:0]   reg_id;
        logic [LAYER_W-1:0] layer;
        logic [ACC_W-1:0]   value;
    } cmd_wr_t;

    // Payload byte count per opcode; 0 marks commit and the invalid opcodes.
    function automatic logic [LEN_W-1:0] payload_len(input logic [REG_W-1:0] reg_id);
        case (reg_id)
            REG_MODE, REG_SCALE, REG_TRANSP, REG_FREEZE:          return LEN_W'(1);
            REG_OFS_X, REG_OFS_Y, REG_CLIP_L, REG_CLIP_R,
            REG_CLIP_T, REG_CLIP_B, REG_FILTER:                    return LEN_W'(2);
            default:                                               return LEN_W'(0);
        endcase
    endfunction

    // Opcodes that address a layer (and therefore need a layer range check).
    function automatic logic reg_is_layered(input logic [REG_W-1:0] reg_id);
        return reg_id <= REG_FILTER;
    endfunction

    // Low bit of a layer's slice in a flattened bus of width-bit fields.
    function automatic int unsigned lane_lo(input int unsigned layer, input int unsigned width);
        return layer * width;
    endfunction

endpackage

// File: rtl/layered_ctrl_bank_cmd_parser.sv
// Byte-stream command parser: header decode, MSB-first payload accumulation,
// discard of rejected commands.
// Ports: clk/rst_n; cmd_start_i aborts to HDR; cmd_byte_i/cmd_valid_i byte
// stream; wr_valid_c/wr_c field write (same cycle as last payload byte);
// commit_req_c commit header seen; err_c command rejected.
module ctrl_cmd_parser
    import layered_ctrl_bank_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_start_i,
    input  logic [BYTE_W-1:0] cmd_byte_i,
    input  logic              cmd_valid_i,
    output logic              wr_valid_c,
    output cmd_wr_t           wr_c,
    output logic              commit_req_c,
    output logic              err_c
);

    localparam int unsigned LAYER_CMP_W = LAYER_W + 1;

    typedef enum logic [1:0] {ST_HDR, ST_PAYLOAD, ST_DISCARD} state_e;

    state_e             state_q, state_d;
    logic [REG_W-1:0]   reg_q, reg_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    logic [ACC_W-1:0]   acc_next;
    logic [LEN_W-1:0]   cnt_inc;
    logic [REG_W-1:0]   hdr_reg;
    logic [LAYER_W-1:0] hdr_layer;

    // Next-state, accumulator and strobe decode.
    always_comb begin
        state_d      = state_q;
        reg_d        = reg_q;
        layer_d      = layer_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        acc_next     = {acc_q[ACC_W-BYTE_W-1:0], cmd_byte_i};
        cnt_inc      = cnt_q + LEN_W'(1);
        hdr_reg      = cmd_byte_i[BYTE_W-1:LAYER_W];
        hdr_layer    = cmd_byte_i[LAYER_W-1:0];
        wr_valid_c   = 1'b0;
        wr_c.reg_id  = reg_q;
        wr_c.layer   = layer_q;
        wr_c.value   = acc_next;
        commit_req_c = 1'b0;
        err_c        = 1'b0;

        // cmd_start outranks a coincident byte, which is dropped.
        if (cmd_start_i) begin
            state_d = ST_HDR;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (cmd_valid_i) begin
            case (state_q)
                ST_HDR: begin
                    reg_d   = hdr_reg;
                    layer_d = hdr_layer;
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (hdr_reg == REG_COMMIT) begin
                        commit_req_c = 1'b1;
                    end else if ((payload_len(hdr_reg) == LEN_W'(0)) ||
                                 (reg_is_layered(hdr_reg) &&
                                  ({1'b0, hdr_layer} >= LAYER_CMP_W'(NUM_LAYERS)))) begin
                        err_c   = 1'b1;
                        state_d = ST_DISCARD;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (cnt_inc == payload_len(reg_q)) begin
                        wr_valid_c = 1'b1;
                        state_d    = ST_HDR;
                        cnt_d      = '0;
                        acc_d      = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        acc_d = acc_next;
                    end
                end
                ST_DISCARD: state_d = ST_DISCARD;
                default:    state_d = ST_HDR;
            endcase
        end
    end

    // Parser state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HDR;
            reg_q   <= '0;
            layer_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            layer_q <= layer_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/layered_ctrl_bank.sv
// Multi-layer compositing control bank: the parser writes a shadow bank that
// is copied atomically to the active (output) bank at a frame boundary.
// Ports: clk/rst_n; cmd_start/cmd_byte/cmd_valid command stream; frame_start
// pulse at pixel (0,0); ctrl_* flattened per-layer buses (layer i in slice
// i); ctrl_fg_freeze global, unshadowed; commit_pending/commit_done commit
// status; err_count saturating rejected-command count.
module layered_ctrl_bank
    import layered_ctrl_bank_pkg::*;
#(
    parameter int unsigned NUM_LAYERS             = 2,
    parameter int unsigned PRECISION              = 11,
    parameter int unsigned PIXEL_SIZE             = 16,
    parameter int unsigned TRANSPARENCY_PRECISION = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cmd_start,
    input  logic [BYTE_W-1:0]                     cmd_byte,
    input  logic                                  cmd_valid,
    input  logic                                  frame_start,
    output logic [MODE_W*NUM_LAYERS-1:0]          ctrl_overlay_mode,
    output logic [SCALE_W*NUM_LAYERS-1:0]         ctrl_fg_scale,
    output logic [(PRECISION+1)*NUM_LAYERS-1:0]   ctrl_fg_offset_x,
    output logic [(PRECISION+1)*NUM_LAYERS-1:0]   ctrl_fg_offset_y,
    output logic [TRANSPARENCY_PRECISION*NUM_LAYERS-1:0] ctrl_fg_transparency,
    output logic [PRECISION*NUM_LAYERS-1:0]       ctrl_fg_clip_left,
    output logic [PRECISION*NUM_LAYERS-1:0]       ctrl_fg_clip_right,
    output logic [PRECISION*NUM_LAYERS-1:0]       ctrl_fg_clip_top,
    output logic [PRECISION*NUM_LAYERS-1:0]       ctrl_fg_clip_bottom,
    output logic [PIXEL_SIZE*NUM_LAYERS-1:0]      ctrl_green_screen_filter,
    output logic                                  ctrl_fg_freeze,
    output logic                                  commit_pending,
    output logic                                  commit_done,
    output logic [ERR_W-1:0]                      err_count
);

    localparam int unsigned OFS_W  = PRECISION + 1;
    localparam int unsigned CLIP_W = PRECISION;
    localparam int unsigned TR_W   = TRANSPARENCY_PRECISION;
    localparam int unsigned FILT_W = PIXEL_SIZE;

    typedef struct packed {
        logic [MODE_W*NUM_LAYERS-1:0]  mode;
        logic [SCALE_W*NUM_LAYERS-1:0] scale;
        logic [OFS_W*NUM_LAYERS-1:0]   ofs_x;
        logic [OFS_W*NUM_LAYERS-1:0]   ofs_y;
        logic [TR_W*NUM_LAYERS-1:0]    transp;
        logic [CLIP_W*NUM_LAYERS-1:0]  clip_l;
        logic [CLIP_W*NUM_LAYERS-1:0]  clip_r;
        logic [CLIP_W*NUM_LAYERS-1:0]  clip_t;
        logic [CLIP_W*NUM_LAYERS-1:0]  clip_b;
        logic [FILT_W*NUM_LAYERS-1:0]  filt;
    } bank_t;

    bank_t            sh_q, sh_d, act_q, act_d;
    logic             freeze_q, freeze_d;
    logic             pending_q, pending_d;
    logic             done_q, done_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             apply;

    logic             wr_valid_c;
    cmd_wr_t          wr_c;
    logic             commit_req_c;
    logic             err_c;

    ctrl_cmd_parser #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_parser (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_start_i  (cmd_start),
        .cmd_byte_i   (cmd_byte),
        .cmd_valid_i  (cmd_valid),
        .wr_valid_c   (wr_valid_c),
        .wr_c         (wr_c),
        .commit_req_c (commit_req_c),
        .err_c        (err_c)
    );

    // Shadow writes, frame-boundary commit and error counting.
    always_comb begin
        sh_d     = sh_q;
        freeze_d = freeze_q;
        if (wr_valid_c) begin
            if (wr_c.reg_id == REG_FREEZE) begin
                freeze_d = wr_c.value[0];
            end
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                if (reg_is_layered(wr_c.reg_id) && (wr_c.layer == LAYER_W'(i))) begin
                    case (wr_c.reg_id)
                        REG_MODE:   sh_d.mode[lane_lo(i, MODE_W) +: MODE_W]    = MODE_W'(wr_c.value);
                        REG_SCALE:  sh_d.scale[lane_lo(i, SCALE_W) +: SCALE_W] = SCALE_W'(wr_c.value);
                        REG_TRANSP: sh_d.transp[lane_lo(i, TR_W) +: TR_W]      = TR_W'(wr_c.value);
                        REG_OFS_X:  sh_d.ofs_x[lane_lo(i, OFS_W) +: OFS_W]     = OFS_W'(wr_c.value);
                        REG_OFS_Y:  sh_d.ofs_y[lane_lo(i, OFS_W) +: OFS_W]     = OFS_W'(wr_c.value);
                        REG_CLIP_L: sh_d.clip_l[lane_lo(i, CLIP_W) +: CLIP_W]  = CLIP_W'(wr_c.value);
                        REG_CLIP_R: sh_d.clip_r[lane_lo(i, CLIP_W) +: CLIP_W]  = CLIP_W'(wr_c.value);
                        REG_CLIP_T: sh_d.clip_t[lane_lo(i, CLIP_W) +: CLIP_W]  = CLIP_W'(wr_c.value);
                        REG_CLIP_B: sh_d.clip_b[lane_lo(i, CLIP_W) +: CLIP_W]  = CLIP_W'(wr_c.value);
                        REG_FILTER: sh_d.filt[lane_lo(i, FILT_W) +: FILT_W]    = FILT_W'(wr_c.value);
                        default:    sh_d.filt[lane_lo(i, FILT_W) +: FILT_W]    = sh_q.filt[lane_lo(i, FILT_W) +: FILT_W];
                    endcase
                end
            end
        end

        // Copy uses the registered shadow, so a coincident write misses this frame;
        // a commit header arriving with frame_start only sets pending for the next one.
        apply     = frame_start && pending_q;
        act_d     = apply ? sh_q : act_q;
        pending_d = commit_req_c || (pending_q && !frame_start);
        done_d    = apply;
        err_d     = (err_c && (err_q != {ERR_W{1'b1}})) ? err_q + ERR_W'(1) : err_q;
    end

    // Bank and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q      <= '0;
            act_q     <= '0;
            freeze_q  <= 1'b0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            sh_q      <= sh_d;
            act_q     <= act_d;
            freeze_q  <= freeze_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ctrl_overlay_mode        = act_q.mode;
    assign ctrl_fg_scale            = act_q.scale;
    assign ctrl_fg_offset_x         = act_q.ofs_x;
    assign ctrl_fg_offset_y         = act_q.ofs_y;
    assign ctrl_fg_transparency     = act_q.transp;
    assign ctrl_fg_clip_left        = act_q.clip_l;
    assign ctrl_fg_clip_right       = act_q.clip_r;
    assign ctrl_fg_clip_top         = act_q.clip_t;
    assign ctrl_fg_clip_bottom      = act_q.clip_b;
    assign ctrl_green_screen_filter = act_q.filt;
    assign ctrl_fg_freeze           = freeze_q;
    assign commit_pending           = pending_q;
    assign commit_done              = done_q;
    assign err_count                = err_q;

endmodule

// File: tb/tb_layered_ctrl_bank.sv
// Self-checking bench for layered_ctrl_bank: a command-level model of the
// shadow bank pushes expected active-bank snapshots at each committing
// frame_start; every commit_done pulse pops one and compares all fields.
module tb_layered_ctrl_bank;

    localparam int unsigned NL = 2;
    localparam int unsigned PR = 11;
    localparam int unsigned PS = 16;
    localparam int unsigned TP = 3;

    logic                  clk;
    logic                  rst_n;
    logic                  cmd_start;
    logic [7:0]            cmd_byte;
    logic                  cmd_valid;
    logic                  frame_start;
    logic [2*NL-1:0]       ctrl_overlay_mode;
    logic [2*NL-1:0]       ctrl_fg_scale;
    logic [(PR+1)*NL-1:0]  ctrl_fg_offset_x;
    logic [(PR+1)*NL-1:0]  ctrl_fg_offset_y;
    logic [TP*NL-1:0]      ctrl_fg_transparency;
    logic [PR*NL-1:0]      ctrl_fg_clip_left;
    logic [PR*NL-1:0]      ctrl_fg_clip_right;
    logic [PR*NL-1:0]      ctrl_fg_clip_top;
    logic [PR*NL-1:0]      ctrl_fg_clip_bottom;
    logic [PS*NL-1:0]      ctrl_green_screen_filter;
    logic                  ctrl_fg_freeze;
    logic                  commit_pending;
    logic                  commit_done;
    logic [7:0]            err_count;

    layered_ctrl_bank #(
        .NUM_LAYERS             (NL),
        .PRECISION              (PR),
        .PIXEL_SIZE             (PS),
        .TRANSPARENCY_PRECISION (TP)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .cmd_start                (cmd_start),
        .cmd_byte                 (cmd_byte),
        .cmd_valid                (cmd_valid),
        .frame_start              (frame_start),
        .ctrl_overlay_mode        (ctrl_overlay_mode),
        .ctrl_fg_scale            (ctrl_fg_scale),
        .ctrl_fg_offset_x         (ctrl_fg_offset_x),
        .ctrl_fg_offset_y         (ctrl_fg_offset_y),
        .ctrl_fg_transparency     (ctrl_fg_transparency),
        .ctrl_fg_clip_left        (ctrl_fg_clip_left),
        .ctrl_fg_clip_right       (ctrl_fg_clip_right),
        .ctrl_fg_clip_top         (ctrl_fg_clip_top),
        .ctrl_fg_clip_bottom      (ctrl_fg_clip_bottom),
        .ctrl_green_screen_filter (ctrl_green_screen_filter),
        .ctrl_fg_freeze           (ctrl_fg_freeze),
        .commit_pending           (commit_pending),
        .commit_done              (commit_done),
        .err_count                (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: [reg 0..9][layer] field values, already truncated to field width.
    typedef logic [9:0][NL-1:0][15:0] snap_t;

    snap_t m_sh;
    snap_t exp_q[$];
    bit    m_pending;
    int    m_err;
    int    exp_done;
    int    got_done;
    int    errors;
    int    checks;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] fmask(input int r);
        case (r)
            0, 1:       return 16'h0003;
            2:          return 16'h0007;
            3, 4:       return 16'h0FFF;
            5, 6, 7, 8: return 16'h07FF;
            default:    return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [15:0] dut_field(input int r, input int l);
        case (r)
            0:       return 16'(ctrl_overlay_mode[l*2 +: 2]);
            1:       return 16'(ctrl_fg_scale[l*2 +: 2]);
            2:       return 16'(ctrl_fg_transparency[l*TP +: TP]);
            3:       return 16'(ctrl_fg_offset_x[l*(PR+1) +: PR+1]);
            4:       return 16'(ctrl_fg_offset_y[l*(PR+1) +: PR+1]);
            5:       return 16'(ctrl_fg_clip_left[l*PR +: PR]);
            6:       return 16'(ctrl_fg_clip_right[l*PR +: PR]);
            7:       return 16'(ctrl_fg_clip_top[l*PR +: PR]);
            8:       return 16'(ctrl_fg_clip_bottom[l*PR +: PR]);
            default: return 16'(ctrl_green_screen_filter[l*PS +: PS]);
        endcase
    endfunction

    // Scoreboard consumer: every commit_done pulse must match the oldest snapshot.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && commit_done === 1'b1) begin
            snap_t s;
            got_done++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_commit_done", 32'd1, 32'd0);
            end else begin
                s = exp_q.pop_front();
                for (int r = 0; r < 10; r++)
                    for (int l = 0; l < int'(NL); l++)
                        check_eq($sformatf("commit_r%0d_l%0d", r, l), 32'(dut_field(r, l)), 32'(s[r][l]));
            end
        end
    end

    // Drivers: each is entered just after a falling edge and consumes one cycle.
    task automatic send(input logic [7:0] b);
        cmd_byte = b; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic start_pulse();
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic model_frame();
        if (m_pending) begin
            exp_q.push_back(m_sh);
            exp_done++;
            m_pending = 1'b0;
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        model_frame();
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic commit();
        send(8'hF0);
        m_pending = 1'b1;
    endtask

    task automatic frame_with_commit();
        frame_start = 1'b1; cmd_byte = 8'hF0; cmd_valid = 1'b1;
        model_frame();
        m_pending = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; cmd_valid = 1'b0;
    endtask

    task automatic wr_cmd(input int r, input int l, input logic [15:0] v);
        send({4'(r), 4'(l)});
        if (r >= 3) begin
            send(v[15:8]);
            send(v[7:0]);
        end else begin
            send(v[7:0]);
        end
        m_sh[r][l] = v & fmask(r);
    endtask

    // One-byte field whose last byte coincides with a committing frame_start.
    task automatic wr_last_at_frame(input int r, input int l, input logic [7:0] v);
        send({4'(r), 4'(l)});
        frame_start = 1'b1; cmd_byte = v; cmd_valid = 1'b1;
        model_frame();
        m_sh[r][l] = 16'(v) & fmask(r);
        @(negedge clk);
        frame_start = 1'b0; cmd_valid = 1'b0;
    endtask

    task automatic model_err();
        if (m_err < 255) m_err++;
    endtask

    initial begin
        errors = 0; checks = 0; m_err = 0; m_pending = 1'b0;
        exp_done = 0; got_done = 0; m_sh = '0;
        rst_n = 1'b0; cmd_start = 1'b0; cmd_byte = 8'h00; cmd_valid = 1'b0; frame_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state.
        check_eq("rst_mode", 32'(ctrl_overlay_mode), 32'd0);
        check_eq("rst_scale", 32'(ctrl_fg_scale), 32'd0);
        check_eq("rst_ofs_x", 32'(ctrl_fg_offset_x), 32'd0);
        check_eq("rst_ofs_y", 32'(ctrl_fg_offset_y), 32'd0);
        check_eq("rst_transp", 32'(ctrl_fg_transparency), 32'd0);
        check_eq("rst_clip_l", 32'(ctrl_fg_clip_left), 32'd0);
        check_eq("rst_clip_b", 32'(ctrl_fg_clip_bottom), 32'd0);
        check_eq("rst_filter", 32'(ctrl_green_screen_filter), 32'd0);
        check_eq("rst_freeze", 32'(ctrl_fg_freeze), 32'd0);
        check_eq("rst_pending", 32'(commit_pending), 32'd0);
        check_eq("rst_done", 32'(commit_done), 32'd0);
        check_eq("rst_err", 32'(err_count), 32'd0);

        // Offset_x layer 1 = -16, visible only after the committing frame.
        wr_cmd(3, 1, 16'hFFF0);
        commit();
        check_eq("ofs_pending", 32'(commit_pending), 32'd1);
        check_eq("ofs_before_frame", 32'(ctrl_fg_offset_x), 32'd0);
        frame();
        check_eq("ofs_after_frame", 32'(ctrl_fg_offset_x), 32'h00FF_0000);
        check_eq("ofs_pending_clr", 32'(commit_pending), 32'd0);
        @(negedge clk);
        check_eq("ofs_done_one_pulse", 32'(commit_done), 32'd0);

        // Aborted clip_left write never lands; next header parses normally.
        send(8'h51); send(8'h12); start_pulse();
        commit(); frame();
        check_eq("abort_clip_l", 32'(ctrl_fg_clip_left), 32'd0);
        wr_cmd(5, 1, 16'h0123);
        commit(); frame();
        check_eq("clip_l_after_abort", 32'(ctrl_fg_clip_left), 32'({11'h123, 11'h000}));

        // Invalid opcode discards until cmd_start; following command lands.
        send(8'hA0); model_err();
        send(8'h01); send(8'h02); send(8'h03);
        start_pulse();
        check_eq("err_invalid_reg", 32'(err_count), 32'(m_err));
        wr_cmd(2, 0, 16'h0005);
        check_eq("transp_shadow_only", 32'(ctrl_fg_transparency), 32'd0);
        commit(); frame();
        check_eq("transp_applied", 32'(ctrl_fg_transparency), 32'h05);

        // cmd_start with a coincident byte: the byte is dropped.
        send(8'h21);
        cmd_start = 1'b1; cmd_byte = 8'h07; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0; cmd_valid = 1'b0;
        wr_cmd(2, 1, 16'h0006);

        // Commit header coincident with frame_start waits for the next frame.
        wr_cmd(1, 0, 16'h0013);
        frame_with_commit();
        check_eq("coinc_no_update", 32'(ctrl_fg_scale), 32'd0);
        check_eq("coinc_pending", 32'(commit_pending), 32'd1);
        frame();
        check_eq("coinc_next_frame", 32'(ctrl_fg_scale), 32'h3);

        // Shadow write in the copy cycle reaches the shadow only.
        commit();
        wr_last_at_frame(0, 1, 8'h02);
        check_eq("copy_pre_write", 32'(ctrl_overlay_mode), 32'd0);
        commit(); frame();
        check_eq("copy_write_later", 32'(ctrl_overlay_mode), 32'b1000);

        // Mixed random field writes, merged commits, one frame each.
        for (int k = 0; k < 6; k++) begin
            wr_cmd(int'($urandom_range(0, 9)), int'($urandom_range(0, NL - 1)), 16'($urandom));
            wr_cmd(int'($urandom_range(0, 9)), int'($urandom_range(0, NL - 1)), 16'($urandom));
            commit(); commit();
            frame();
        end

        // Out-of-range layer rejected; freeze acts immediately without commit.
        send(8'h0F); model_err();
        check_eq("err_bad_layer", 32'(err_count), 32'(m_err));
        start_pulse();
        send(8'hE0); send(8'h01);
        check_eq("freeze_immediate", 32'(ctrl_fg_freeze), 32'd1);
        check_eq("freeze_no_pending", 32'(commit_pending), 32'd0);

        // err_count saturates.
        for (int k = 0; k < 260; k++) begin
            send(8'hB0); model_err();
            start_pulse();
        end
        check_eq("err_saturate", 32'(err_count), 32'd255);

        repeat (3) @(negedge clk);
        check_eq("commit_done_count", 32'(got_done), 32'(exp_done));
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layered_ctrl_bank.md
Name: layered_ctrl_bank

Overview:
- Parametrised successor to the single-layer SPI control path: holds compositing control settings for NUM_LAYERS foreground layers.
- A byte-oriented command parser writes a shadow bank. The shadow bank is committed atomically to the active bank at a frame boundary, so no frame is ever composited with half-updated settings.
- Sits between the SPI byte deserialiser and the multi-layer pipeline; drives flattened per-layer control buses.

Parameters:
- NUM_LAYERS, 2, number of foreground layers (1..16).
- PRECISION, 11, unsigned screen-coordinate width; offsets are PRECISION+1 signed.
- PIXEL_SIZE, 16, green-screen filter width.
- TRANSPARENCY_PRECISION, 3, transparency field width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_start  in  1  pulse at SS assertion; aborts any command and returns the parser to HDR.
- cmd_byte  in  8  received command byte.
- cmd_valid  in  1  cmd_byte valid this cycle; always accepted.
- frame_start  in  1  one-cycle pulse at pixel (0,0).
- ctrl_overlay_mode  out  2*NUM_LAYERS  per layer; layer i at [2i+1:2i].
- ctrl_fg_scale  out  2*NUM_LAYERS  per layer.
- ctrl_fg_offset_x, ctrl_fg_offset_y  out  (PRECISION+1)*NUM_LAYERS  signed, per layer.
- ctrl_fg_transparency  out  TRANSPARENCY_PRECISION*NUM_LAYERS.
- ctrl_fg_clip_left/right/top/bottom  out  PRECISION*NUM_LAYERS each.
- ctrl_green_screen_filter  out  PIXEL_SIZE*NUM_LAYERS.
- ctrl_fg_freeze  out  1  global; takes effect immediately, not shadowed.
- commit_pending  out  1  commit requested, not yet applied.
- commit_done  out  1  one-cycle pulse when the active bank is updated.
- err_count  out  8  saturating count of rejected commands.

Behaviour:
- Reset: every active and shadow field is 0 (overlay_mode 0 = no foreground), freeze 0, commit_pending 0, commit_done 0, err_count 0, parser in HDR.
- Header byte: [7:4] = REG, [3:0] = LAYER.
- REG encoding and payload byte count:
  - 0 mode: 1 byte.
  - 1 scale: 1 byte.
  - 2 transparency: 1 byte.
  - 3 offset_x: 2 bytes.
  - 4 offset_y: 2 bytes.
  - 5–8 clip left/right/top/bottom: 2 bytes each.
  - 9 filter: 2 bytes.
  - 14 freeze: 1 byte; bit0 is the freeze value; LAYER ignored.
  - 15 commit: 0 bytes.
  - 10–13: invalid.
- Payload is MSB first, assembled into a 16-bit accumulator. The field takes the low bits; excess bits are ignored. Offsets take the low PRECISION+1 bits as two's complement.
- Parser FSM:
  - HDR → PAYLOAD when a valid REG has nonzero length and LAYER < NUM_LAYERS.
  - HDR → HDR on commit, after setting commit_pending.
  - HDR → DISCARD on invalid REG, or LAYER >= NUM_LAYERS for REG 0–9; err_count increments.
  - PAYLOAD counts bytes. On the last byte it writes the shadow field (or freeze) in the same cycle, then → HDR.
  - DISCARD swallows bytes until cmd_start.
  - cmd_start in any state → HDR and clears the byte counter. A partially received field is never written.
  - cmd_start and cmd_valid in the same cycle: cmd_start wins and the byte is dropped.
- Commit rules:
  - A cycle with frame_start and commit_pending copies shadow → active. The next cycle, outputs show the new values, commit_done = 1 and commit_pending = 0.
  - A commit header arriving in the same cycle as frame_start is not applied at that frame_start; it waits for the next one.
  - A shadow write in the same cycle as the copy: the copy takes the pre-write shadow; the write lands in the shadow only.
  - Repeated commits before a frame_start merge into one.
- err_count saturates at 255.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - REG_* opcode constants.
  - A payload-length function of REG.
  - Field-width localparams.
  - Flattened-bus slice helpers (layer index → bit offset).
- One natural sub-module: ctrl_cmd_parser (FSM, accumulator, byte counter). It emits a write strobe with reg/layer/value, plus commit_req and error pulses.
- layered_ctrl_bank keeps the shadow/active banks and commit logic.

Test Plan:
- Reset then no commands → all outputs 0, commit_pending 0, err_count 0.
- Send 0x31,0xFF,0xF0 (offset_x layer 1 = -16), then 0xF0, then frame_start → layer 1 offset_x reads 0xFF0 (12-bit) only the cycle after frame_start; commit_done pulses once; layer 0 unchanged.
- Send header 0x51 plus 1 byte, then cmd_start, then frame_start with commit → layer 1 clip_left stays 0; the parser accepts the next header normally.
- Header 0xA0 (invalid REG), then 3 bytes, then cmd_start, then 0x02,0x05 → err_count = 1; layer 0 transparency shadow = 5 and is applied after a commit and frame_start.
- Commit header coincident with frame_start → no update that frame; update and commit_done at the next frame_start.
- Header 0x0F with NUM_LAYERS=2 → err_count increments. Then 0xE0,0x01 → ctrl_fg_freeze = 1 the cycle after the payload byte, with no commit needed.
